// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between a
// load/store unit (requester 0) and a debug/DMA port (requester 1).
module data_memory_arbiter #(
  parameter int address_width = 32,
  parameter int word_width    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid_0,
  output logic                     req_ready_0,
  input  logic                     req_write_0,
  input  logic [address_width-1:0] req_address_0,
  input  logic [word_width-1:0]    req_write_data_0,
  output logic                     resp_valid_0,
  input  logic                     resp_ready_0,
  output logic [word_width-1:0]    resp_data_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_1,
  input  logic                     req_write_1,
  input  logic [address_width-1:0] req_address_1,
  input  logic [word_width-1:0]    req_write_data_1,
  output logic                     resp_valid_1,
  input  logic                     resp_ready_1,
  output logic [word_width-1:0]    resp_data_1,
  output logic                     mem_write_enable,
  output logic [address_width-1:0] mem_address,
  output logic [word_width-1:0]    mem_write_data,
  input  logic [word_width-1:0]    mem_read_data
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [1:0]               req_valid;
  logic [1:0]               req_write;
  logic [1:0]               resp_ready;
  logic [address_width-1:0] req_address [2];
  logic [word_width-1:0]    req_write_data [2];

  logic [1:0]            eligible;
  logic [1:0]            grant;
  logic [1:0]            read_accept;
  logic                  sel;
  logic [1:0]            full_reg, full_next;
  logic                  prio_reg, prio_next;
  logic [word_width-1:0] resp_data_reg [2];
  logic [word_width-1:0] resp_data_next [2];

  assign req_valid         = {req_valid_1, req_valid_0};
  assign req_write         = {req_write_1, req_write_0};
  assign resp_ready        = {resp_ready_1, resp_ready_0};
  assign req_address[0]    = req_address_0;
  assign req_address[1]    = req_address_1;
  assign req_write_data[0] = req_write_data_0;
  assign req_write_data[1] = req_write_data_1;

  // A pending response blocks its requester; eligibility uses registered state only.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign eligible[gi]    = req_valid[gi] & (full_reg[gi] == EMPTY);
      assign read_accept[gi] = grant[gi] & ~req_write[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_reg      <= {EMPTY, EMPTY};
      prio_reg      <= 1'b0;
      resp_data_reg <= '{default: '0};
    end else begin
      full_reg      <= full_next;
      prio_reg      <= prio_next;
      resp_data_reg <= resp_data_next;
    end
  end

  always_comb begin
    prio_next = prio_reg;
    if (grant[0]) begin
      prio_next = 1'b1;
    end else if (grant[1]) begin
      prio_next = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      full_next[i]      = full_reg[i];
      resp_data_next[i] = resp_data_reg[i];
      if (full_reg[i] == EMPTY) begin
        if (read_accept[i]) begin
          full_next[i]      = FULL;
          resp_data_next[i] = mem_read_data;
        end
      end else if (resp_ready[i]) begin
        full_next[i] = EMPTY;
      end
    end
  end

  // Grant and memory drive; everything is held idle while reset is asserted.
  always_comb begin
    grant = 2'b00;
    if (reset_n) begin
      if (eligible == 2'b11) begin
        grant = prio_reg ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
    sel              = grant[1];
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (|grant) begin
      mem_write_enable = req_write[sel];
      mem_address      = req_address[sel];
      mem_write_data   = req_write_data[sel];
    end
  end

  assign req_ready_0  = grant[0];
  assign req_ready_1  = grant[1];
  assign resp_valid_0 = full_reg[0];
  assign resp_valid_1 = full_reg[1];
  assign resp_data_0  = resp_data_reg[0];
  assign resp_data_1  = resp_data_reg[1];

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural memory, shadow copy for expected
// read data, and per-requester queues of expected responses.
module tb_data_memory_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid_0, req_ready_0, req_write_0, resp_valid_0, resp_ready_0;
  logic          req_valid_1, req_ready_1, req_write_1, resp_valid_1, resp_ready_1;
  logic [AW-1:0] req_address_0, req_address_1, mem_address;
  logic [WW-1:0] req_write_data_0, req_write_data_1, resp_data_0, resp_data_1;
  logic          mem_write_enable;
  logic [WW-1:0] mem_write_data, mem_read_data;

  logic [WW-1:0] mem [256];
  logic [WW-1:0] shadow [256];
  logic [WW-1:0] q0 [$];
  logic [WW-1:0] q1 [$];
  int            vectors = 0;
  int            miscompares = 0;

  data_memory_arbiter #(.address_width(AW), .word_width(WW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_write_0(req_write_0),
    .req_address_0(req_address_0), .req_write_data_0(req_write_data_0),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0), .resp_data_0(resp_data_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_write_1(req_write_1),
    .req_address_1(req_address_1), .req_write_data_1(req_write_data_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .resp_data_1(resp_data_1),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
  end

  function automatic logic [WW-1:0] pop0();
    if (q0.size() == 0) return 'x;
    return q0.pop_front();
  endfunction

  function automatic logic [WW-1:0] pop1();
    if (q1.size() == 0) return 'x;
    return q1.pop_front();
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid_0 = 0; req_write_0 = 0; req_address_0 = '0; req_write_data_0 = '0; resp_ready_0 = 0;
    req_valid_1 = 0; req_write_1 = 0; req_address_1 = '0; req_write_data_1 = '0; resp_ready_1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick();
    reset_n = 0;
    #2;
    reset_n = 1;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    logic [WW-1:0] e;
    idle_inputs();
    req_valid_0 = 1; req_write_0 = 1; req_address_0 = 32'h20;
    req_valid_1 = 1; req_write_1 = 1; req_address_1 = 32'h24;
    #1 reset_n = 0;
    sample();
    vectors++; if (req_ready_0 !== 1'b0) begin miscompares++; $display("FAIL rst_ready0 got=%b exp=0", req_ready_0); end
    vectors++; if (req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got=%b exp=0", req_ready_1); end
    vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", mem_write_enable); end
    vectors++; if (resp_valid_0 !== 1'b0) begin miscompares++; $display("FAIL rst_rv0 got=%b exp=0", resp_valid_0); end
    vectors++; if (resp_valid_1 !== 1'b0) begin miscompares++; $display("FAIL rst_rv1 got=%b exp=0", resp_valid_1); end
    vectors++; if (resp_data_0 !== '0) begin miscompares++; $display("FAIL rst_rd0 got=%h exp=0", resp_data_0); end
    tick();
    reset_n = 1; req_write_0 = 0; req_write_1 = 0; resp_ready_0 = 1; resp_ready_1 = 1;
    sample();
    vectors++; if (req_ready_0 !== 1'b1) begin miscompares++; $display("FAIL first_grant0 got=%b exp=1", req_ready_0); end
    vectors++; if (req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL first_grant1 got=%b exp=0", req_ready_1); end
    q0.push_back(shadow[8]);
    tick();
    req_valid_0 = 0;
    sample();
    e = pop0();
    vectors++; if (resp_valid_0 !== 1'b1) begin miscompares++; $display("FAIL post_rst_rv0 got=%b exp=1", resp_valid_0); end
    vectors++; if (resp_data_0 !== e) begin miscompares++; $display("FAIL post_rst_rd0 got=%h exp=%h", resp_data_0, e); end
    vectors++; if (req_ready_1 !== 1'b1) begin miscompares++; $display("FAIL post_rst_grant1 got=%b exp=1", req_ready_1); end
    q1.push_back(shadow[9]);
    tick();
    req_valid_1 = 0;
    sample();
    e = pop1();
    vectors++; if (resp_valid_1 !== 1'b1) begin miscompares++; $display("FAIL post_rst_rv1 got=%b exp=1", resp_valid_1); end
    vectors++; if (resp_data_1 !== e) begin miscompares++; $display("FAIL post_rst_rd1 got=%h exp=%h", resp_data_1, e); end
    tick();
  endtask

  task automatic test_write_read();
    logic [WW-1:0] e;
    do_reset();
    req_valid_0 = 1; req_write_0 = 1; req_address_0 = 32'h10; req_write_data_0 = 32'hDEADBEEF;
    sample();
    vectors++; if (req_ready_0 !== 1'b1) begin miscompares++; $display("FAIL wr_ready0 got=%b exp=1", req_ready_0); end
    vectors++; if (mem_write_enable !== 1'b1) begin miscompares++; $display("FAIL wr_we got=%b exp=1", mem_write_enable); end
    vectors++; if (mem_address !== 32'h10) begin miscompares++; $display("FAIL wr_addr got=%h exp=10", mem_address); end
    vectors++; if (mem_write_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_data got=%h exp=deadbeef", mem_write_data); end
    shadow[4] = 32'hDEADBEEF;
    tick();
    req_write_0 = 0;
    sample();
    vectors++; if (req_ready_0 !== 1'b1) begin miscompares++; $display("FAIL rd_ready0 got=%b exp=1", req_ready_0); end
    vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rd_we got=%b exp=0", mem_write_enable); end
    vectors++; if (resp_valid_0 !== 1'b0) begin miscompares++; $display("FAIL wr_no_resp got=%b exp=0", resp_valid_0); end
    q0.push_back(shadow[4]);
    tick();
    req_valid_0 = 0; resp_ready_0 = 1;
    sample();
    e = pop0();
    vectors++; if (resp_valid_0 !== 1'b1) begin miscompares++; $display("FAIL rd_rv0 got=%b exp=1", resp_valid_0); end
    vectors++; if (resp_data_0 !== e) begin miscompares++; $display("FAIL rd_after_wr got=%h exp=%h", resp_data_0, e); end
    tick();
    sample();
    vectors++; if (resp_valid_0 !== 1'b0) begin miscompares++; $display("FAIL rd_retire got=%b exp=0", resp_valid_0); end
    tick();
  endtask

  task automatic test_alternate();
    logic [WW-1:0] e;
    int g;
    do_reset();
    req_valid_0 = 1; req_address_0 = 32'h100; resp_ready_0 = 1;
    req_valid_1 = 1; req_address_1 = 32'h200; resp_ready_1 = 1;
    for (int k = 0; k < 8; k++) begin
      g = k % 2;
      sample();
      vectors++; if (req_ready_0 !== (g == 0)) begin miscompares++; $display("FAIL alt_ready0 cyc=%0d got=%b exp=%b", k, req_ready_0, (g == 0)); end
      vectors++; if (req_ready_1 !== (g == 1)) begin miscompares++; $display("FAIL alt_ready1 cyc=%0d got=%b exp=%b", k, req_ready_1, (g == 1)); end
      if (k > 0) begin
        if (g == 1) begin
          e = pop0();
          vectors++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== e) begin miscompares++; $display("FAIL alt_resp0 cyc=%0d got=%b/%h exp=1/%h", k, resp_valid_0, resp_data_0, e); end
        end else begin
          e = pop1();
          vectors++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== e) begin miscompares++; $display("FAIL alt_resp1 cyc=%0d got=%b/%h exp=1/%h", k, resp_valid_1, resp_data_1, e); end
        end
      end
      if (g == 0) q0.push_back(shadow[req_address_0[9:2]]);
      else        q1.push_back(shadow[req_address_1[9:2]]);
      tick();
      if (g == 0) req_address_0 = req_address_0 + 4;
      else        req_address_1 = req_address_1 + 4;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    sample();
    e = pop1();
    vectors++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== e) begin miscompares++; $display("FAIL alt_last_resp1 got=%b/%h exp=1/%h", resp_valid_1, resp_data_1, e); end
    tick();
  endtask

  task automatic test_block();
    logic [WW-1:0] e;
    do_reset();
    req_valid_1 = 1; req_address_1 = 32'h300;
    sample();
    vectors++; if (req_ready_1 !== 1'b1) begin miscompares++; $display("FAIL blk_grant1 got=%b exp=1", req_ready_1); end
    q1.push_back(shadow[req_address_1[9:2]]);
    tick();
    req_address_1 = 32'h304;
    req_valid_0 = 1; req_address_0 = 32'h80; resp_ready_0 = 1;
    for (int j = 0; j < 5; j++) begin
      sample();
      e = (q1.size() != 0) ? q1[0] : 'x;
      vectors++; if (req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL blk_ready1 cyc=%0d got=%b exp=0", j, req_ready_1); end
      vectors++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== e) begin miscompares++; $display("FAIL blk_hold1 cyc=%0d got=%b/%h exp=1/%h", j, resp_valid_1, resp_data_1, e); end
      vectors++; if (req_ready_0 !== (j % 2 == 0)) begin miscompares++; $display("FAIL blk_ready0 cyc=%0d got=%b exp=%b", j, req_ready_0, (j % 2 == 0)); end
      if (j % 2 == 1) begin
        e = pop0();
        vectors++; if (resp_data_0 !== e) begin miscompares++; $display("FAIL blk_resp0 cyc=%0d got=%h exp=%h", j, resp_data_0, e); end
      end else begin
        q0.push_back(shadow[req_address_0[9:2]]);
      end
      tick();
      if (j % 2 == 0) req_address_0 = req_address_0 + 4;
    end
    resp_ready_1 = 1; req_valid_0 = 0;
    sample();
    vectors++; if (req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL consume_not_eligible got=%b exp=0", req_ready_1); end
    e = pop0();
    vectors++; if (resp_data_0 !== e) begin miscompares++; $display("FAIL blk_last_resp0 got=%h exp=%h", resp_data_0, e); end
    e = pop1();
    vectors++; if (resp_data_1 !== e) begin miscompares++; $display("FAIL blk_resp1 got=%h exp=%h", resp_data_1, e); end
    tick();
    sample();
    vectors++; if (req_ready_1 !== 1'b1) begin miscompares++; $display("FAIL blk_regrant1 got=%b exp=1", req_ready_1); end
    q1.push_back(shadow[req_address_1[9:2]]);
    tick();
    req_valid_1 = 0;
    sample();
    e = pop1();
    vectors++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== e) begin miscompares++; $display("FAIL blk_resp1b got=%b/%h exp=1/%h", resp_valid_1, resp_data_1, e); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] e;
    do_reset();
    req_valid_0 = 1; req_address_0 = 32'h30;
    sample();
    q0.push_back(shadow[12]);
    tick();
    req_valid_0 = 0;
    sample();
    e = pop0();
    vectors++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== e) begin miscompares++; $display("FAIL mid_pre_resp0 got=%b/%h exp=1/%h", resp_valid_0, resp_data_0, e); end
    #2 reset_n = 0;
    #1;
    vectors++; if (resp_valid_0 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rv0 got=%b exp=0", resp_valid_0); end
    vectors++; if (resp_data_0 !== '0) begin miscompares++; $display("FAIL mid_rst_rd0 got=%h exp=0", resp_data_0); end
    tick();
    req_valid_0 = 1; req_address_0 = 32'h34;
    req_valid_1 = 1; req_address_1 = 32'h38;
    reset_n = 1;
    sample();
    vectors++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL mid_prio got=%b%b exp=01", req_ready_1, req_ready_0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_write_while_full();
    logic [WW-1:0] e;
    do_reset();
    req_valid_0 = 1; req_address_0 = 32'h50;
    sample();
    vectors++; if (req_ready_0 !== 1'b1) begin miscompares++; $display("FAIL wf_grant0 got=%b exp=1", req_ready_0); end
    q0.push_back(shadow[20]);
    tick();
    req_address_0 = 32'h54;
    req_valid_1 = 1; req_write_1 = 1; req_address_1 = 32'h40; req_write_data_1 = 32'h12345678;
    sample();
    vectors++; if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) begin miscompares++; $display("FAIL wf_grant got=%b%b exp=10", req_ready_1, req_ready_0); end
    vectors++; if (mem_write_enable !== 1'b1 || mem_address !== 32'h40 || mem_write_data !== 32'h12345678) begin miscompares++; $display("FAIL wf_mem got=%b/%h/%h exp=1/40/12345678", mem_write_enable, mem_address, mem_write_data); end
    shadow[16] = 32'h12345678;
    tick();
    req_write_1 = 0; resp_ready_0 = 1;
    sample();
    vectors++; if (resp_valid_1 !== 1'b0) begin miscompares++; $display("FAIL wf_no_resp1 got=%b exp=0", resp_valid_1); end
    vectors++; if (mem[16] !== 32'h12345678) begin miscompares++; $display("FAIL wf_mem_commit got=%h exp=12345678", mem[16]); end
    vectors++; if (req_ready_1 !== 1'b1) begin miscompares++; $display("FAIL wf_rd_grant1 got=%b exp=1", req_ready_1); end
    e = pop0();
    vectors++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== e) begin miscompares++; $display("FAIL wf_resp0 got=%b/%h exp=1/%h", resp_valid_0, resp_data_0, e); end
    q1.push_back(shadow[16]);
    tick();
    req_valid_1 = 0;
    sample();
    e = pop1();
    vectors++; if (resp_valid_1 !== 1'b1 || resp_data_1 !== e) begin miscompares++; $display("FAIL wf_resp1 got=%b/%h exp=1/%h", resp_valid_1, resp_data_1, e); end
    vectors++; if (req_ready_0 !== 1'b1) begin miscompares++; $display("FAIL wf_grant0b got=%b exp=1", req_ready_0); end
    q0.push_back(shadow[21]);
    tick();
    req_valid_0 = 0;
    sample();
    e = pop0();
    vectors++; if (resp_valid_0 !== 1'b1 || resp_data_0 !== e) begin miscompares++; $display("FAIL wf_resp0b got=%b/%h exp=1/%h", resp_valid_0, resp_data_0, e); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]    = (WW'(k) * 32'h01000193) ^ 32'h5A5A0000;
      shadow[k] = (WW'(k) * 32'h01000193) ^ 32'h5A5A0000;
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_block();
    test_reset_mid();
    test_write_while_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
